// File: rtl/add_seq_ctrl.sv
// Sequential multi-cycle adder: one SLICE-bit adder is reused over NSLICE cycles
// to form a WIDTH-bit sum with carry-out, framed by IDLE/RUN/DONE control.
module add_seq_ctrl #(
    parameter int WIDTH = 128,
    parameter int SLICE = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state;
    logic [NSLICE-1:0][SLICE-1:0] op_a, op_b, acc, acc_next;
    logic                         carry;
    logic [IDXW-1:0]              idx;
    logic [SLICE-1:0]             s_sum;
    logic                         s_co;
    logic                         accept;

    // The single shared slice adder, steered by the slice index.
    always_comb begin
        {s_co, s_sum} = {1'b0, op_a[idx]} + {1'b0, op_b[idx]} + {{SLICE{1'b0}}, carry};
    end

    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = s_sum;
    end

    assign accept = start && (state == IDLE || state == DONE);

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and accumulator registers are reset too, so no stale data survives an abort.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= s_co;
                    if (idx == LAST_IDX) begin
                        sum   <= acc_next;
                        cout  <= s_co;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized self-checking bench for add_seq_ctrl against a plain-arithmetic model.
module tb_add_seq_ctrl;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;
    logic [W:0] last_res = '0;

    add_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // One operation; with disturb set, operands change and start pulses while busy.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input bit disturb);
        logic [W:0] exp;
        int cyc, busy_cnt;
        exp = model(ta, tb_v, tc);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            a = rnd128(); b = rnd128(); cin = ~tc;
        end
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            if (cyc == 1) check("hold_prev", {cout, sum}, last_res);
            start = disturb && (cyc == 1);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", W'(cyc), 4);
        check("busy_cycles", W'(busy_cnt), 4);
        check("busy_at_done", busy, 0);
        check("result", {cout, sum}, exp);
        last_res = exp;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        logic [W:0]   exp;
        logic [W-1:0] na, nb;
        logic         nc;
        int           cnt;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {cout, sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(128'd1205678900008765, 128'd4563456789087654, 1'b0, 1'b0);
        check("req29_const", {cout, sum}, 129'd5769135689096419);
        do_op({W{1'b1}}, 128'd3, 1'b0, 1'b0);
        do_op(128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0);
        do_op({W{1'b1}}, 128'd0, 1'b1, 1'b0);
        do_op(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd0, 1'b1, 1'b0);
        do_op(128'd1013, 128'd1013, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) do_op(rnd128(), rnd128(), 1'($urandom), i[0]);

        // Back-to-back with start held high; new operands appear only in DONE cycles.
        @(negedge clk);
        na = rnd128(); nb = rnd128(); nc = 1'($urandom);
        a = na; b = nb; cin = nc; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            exp = model(na, nb, nc);
            cnt = 0;
            while (!done && cnt < 20) begin
                a = rnd128(); b = rnd128(); cin = 1'($urandom);
                @(negedge clk);
                cnt++;
            end
            check("b2b_period", W'(cnt), 4);
            check("b2b_result", {cout, sum}, exp);
            last_res = exp;
            na = rnd128(); nb = rnd128(); nc = 1'($urandom);
            a = na; b = nb; cin = nc;
            start = (k < 4);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous abort two cycles into RUN.
        a = rnd128(); b = rnd128(); cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_res", {cout, sum}, 0);
        last_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("no_done_after_abort", W'(cnt), 0);
        do_op(rnd128(), rnd128(), 1'b0, 1'b0);
        do_op({W{1'b1}}, 128'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 128, operand/result width in bits.
REQ-002 SHALL provide parameter SLICE, default 32, adder slice width in bits; WIDTH SHALL be an integer multiple of SLICE; NSLICE = WIDTH/SLICE.
REQ-003 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port start  input  1  request to begin an addition, sampled on rising clk.
REQ-006 SHALL provide port a  input  WIDTH  operand A, captured with accepted start.
REQ-007 SHALL provide port b  input  WIDTH  operand B, captured with accepted start.
REQ-008 SHALL provide port cin  input  1  carry-in, captured with accepted start.
REQ-009 SHALL provide port busy  output  1  high while a sum is in progress.
REQ-010 SHALL provide port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL provide port sum  output  WIDTH  registered result a+b+cin mod 2^WIDTH.
REQ-012 SHALL provide port cout  output  1  registered carry-out of the full-width sum.

Function
REQ-013 SHALL contain exactly one SLICE-bit combinational adder (slice operands, carry-in, SLICE-bit sum, carry-out), reused every RUN cycle.
REQ-014 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 at an edge -> capture a, b, cin into operand registers, carry register <= cin, slice index <= 0, go RUN; start=0 -> stay IDLE.
REQ-016 RUN: each edge SHALL add slice[index] of captured A and B plus carry register, write result into accumulator slice[index], carry register <= slice carry-out, index <= index+1.
REQ-017 RUN: at the edge processing index NSLICE-1 SHALL load sum <= full accumulator (including that slice), cout <= slice carry-out, and go DONE.
REQ-018 DONE: done=1 for exactly that one cycle; next edge -> IDLE, or, if start=1 on that edge, accept new operands per REQ-015 and go RUN (back-to-back).
REQ-019 Latency: start accepted at edge t0 -> done high during the cycle following edge t0+NSLICE (4 cycles for defaults); throughput one result per NSLICE+1 cycles.
REQ-020 busy SHALL be 1 exactly while state is RUN; 0 in IDLE and DONE.
REQ-021 start while RUN SHALL be ignored: no operand capture, no restart, no effect on index or carry.
REQ-022 Operand inputs a, b, cin changing after capture SHALL not affect the in-progress result.
REQ-023 sum and cout SHALL hold their last completed values until the next completion edge; never show partial results.
REQ-024 Arithmetic: {cout,sum} SHALL equal a+b+cin over WIDTH+1 bits; carry SHALL propagate correctly across every slice boundary, including a full-width ripple (all-ones + 1).
REQ-025 Slice index counter SHALL be ceil(log2(NSLICE)) bits minimum and SHALL not wrap during an operation.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk: state <= IDLE, busy=0, done=0, sum=0, cout=0, index=0, carry register=0, operand and accumulator registers=0.
REQ-027 Reset asserted mid-RUN or during DONE SHALL abort the operation; no done pulse SHALL be produced for it after release.
REQ-028 After rst_n deasserts, the first rising clk with start=1 SHALL be accepted normally.

Verification
REQ-029 a=1205678900008765, b=4563456789087654, cin=0, one-cycle start -> done 4 cycles later, sum=5769135689096419, cout=0, busy high exactly 4 cycles.
REQ-030 a=2^128-1, b=3, cin=0 -> sum=2, cout=1; a=2^32-1, b=1, cin=0 -> sum=2^32, cout=0 (slice-boundary carry).
REQ-031 a=1013, b=1013, cin=1 -> sum=2027, cout=0; a,b,cin changed and start pulsed while busy -> result unchanged, no extra done.
REQ-032 Back-to-back: start held high continuously with new operands at each DONE cycle -> done every 5 cycles, each sum correct for operands at its accepted start.
REQ-033 rst_n pulsed low 2 cycles into RUN -> busy, done, sum, cout 0 asynchronously; no done after release; next start yields correct result.
